// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one block-wide data memory between an instruction
// cache (read only) and a data cache (read / write-back), round-robin on ties.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic               MEM_ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t             state_r, state_s;
  logic               gnt_r, gnt_s;
  logic               last_r, last_s;
  logic               mem_read_r, mem_read_s;
  logic               mem_write_r, mem_write_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [BLOCK_W-1:0] wdata_r, wdata_s;
  logic [BLOCK_W-1:0] data_r, data_s;
  logic [7:0]         wait_cnt_r, wait_cnt_s;
  logic               err_r, err_s;
  logic               i_req_s, d_req_s, pick_d_s;
  logic [8:0]         wait_inc_s;
  logic [7:0]         wait_sat_s;
  logic               timeout_s;

  assign i_req_s    = I_READ;
  assign d_req_s    = D_READ | D_WRITE;
  // On a tie the requester that was not served last wins.
  assign pick_d_s   = d_req_s & (~i_req_s | (last_r == GNT_I));
  assign wait_inc_s = {1'b0, wait_cnt_r} + 9'd1;
  assign wait_sat_s = (wait_cnt_r == 8'hFF) ? 8'hFF : wait_inc_s[7:0];
  assign timeout_s  = (wait_inc_s >= 9'(TIMEOUT));

  // Next-state, grant capture and transaction bookkeeping.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    last_s      = last_r;
    mem_read_s  = mem_read_r;
    mem_write_s = mem_write_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    data_s      = data_r;
    wait_cnt_s  = wait_cnt_r;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req_s || d_req_s) begin
          state_s = ISSUE;
          if (pick_d_s) begin
            gnt_s       = GNT_D;
            addr_s      = D_ADDRESS;
            wdata_s     = D_WRITEDATA;
            mem_write_s = D_WRITE;
            mem_read_s  = ~D_WRITE;
          end else begin
            gnt_s       = GNT_I;
            addr_s      = I_ADDRESS;
            wdata_s     = '0;
            mem_write_s = 1'b0;
            mem_read_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s    = WAIT;
        wait_cnt_s = 8'd0;
      end
      WAIT: begin
        // A completing memory wins over a timeout on the same edge.
        if (!MEM_BUSYWAIT) begin
          state_s     = RESP;
          data_s      = mem_read_r ? MEM_READDATA : data_r;
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
        end else if (timeout_s) begin
          state_s     = RESP;
          data_s      = '0;
          err_s       = 1'b1;
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          wait_cnt_s  = wait_sat_s;
        end else begin
          wait_cnt_s  = wait_sat_s;
        end
      end
      RESP: begin
        last_s  = gnt_r;
        state_s = IDLE;
      end
      default: begin
        state_s     = IDLE;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= IDLE;
      gnt_r       <= GNT_I;
      last_r      <= GNT_I;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      data_r      <= '0;
      wait_cnt_r  <= 8'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      last_r      <= last_s;
      mem_read_r  <= mem_read_s;
      mem_write_r <= mem_write_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      data_r      <= data_s;
      wait_cnt_r  <= wait_cnt_s;
      err_r       <= err_s;
    end
  end

  assign MEM_READ      = mem_read_r;
  assign MEM_WRITE     = mem_write_r;
  assign MEM_ADDRESS   = addr_r;
  assign MEM_WRITEDATA = wdata_r;
  assign MEM_ERR       = err_r;
  assign I_READDATA    = data_r;
  assign D_READDATA    = data_r;
  // Busywaits release only during the granted requester's response cycle.
  assign I_BUSYWAIT    = I_READ & ~((state_r == RESP) && (gnt_r == GNT_I));
  assign D_BUSYWAIT    = (D_READ | D_WRITE) & ~((state_r == RESP) && (gnt_r == GNT_D));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter with a cycle-counting
// memory model and a transaction-level arbitration reference.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 255;

  logic         CLK, RESET;
  logic         I_READ, D_READ, D_WRITE;
  logic [27:0]  I_ADDRESS, D_ADDRESS;
  logic [127:0] D_WRITEDATA;
  logic [127:0] I_READDATA, D_READDATA;
  logic         I_BUSYWAIT, D_BUSYWAIT;
  logic         MEM_READ, MEM_WRITE, MEM_ERR;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_pass  = 0;
  int n_total = 0;
  int mem_lat = 1;
  logic [15:0] mem_cnt;

  mem_bus_arbiter #(.ADDR_W(28), .BLOCK_W(128), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_ERR(MEM_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: busy until the command has been up for mem_lat edges.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) mem_cnt <= 16'd0;
    else if (MEM_READ || MEM_WRITE) mem_cnt <= mem_cnt + 16'd1;
    else mem_cnt <= 16'd0;
  end
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (int'(mem_cnt) < mem_lat);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One arbitrated transaction, starting with the winner's request already driven.
  task automatic serve(input string tag, input bit gnt_d, input bit wr, input logic [27:0] addr,
                       input logic [127:0] wdata, input logic [127:0] rdata, input int lat,
                       input int gw, input bit perturb);
    int waited, n, bad, exp_n;
    bit err;
    logic [127:0] exp_data;
    err      = (lat > TIMEOUT);
    exp_n    = err ? TIMEOUT + 1 : lat + 1;
    exp_data = err ? 128'd0 : rdata;
    mem_lat      = lat;
    MEM_READDATA = rdata;
    waited = 0;
    while (!(MEM_READ || MEM_WRITE) && waited < 4) begin
      @(negedge CLK);
      waited++;
    end
    check({tag, "/grant_wait"}, 128'(waited), 128'(gw));
    n   = 0;
    bad = 0;
    while ((MEM_READ || MEM_WRITE) && n < 400) begin
      n++;
      if (MEM_ADDRESS !== addr || MEM_WRITE !== wr || MEM_READ !== !wr ||
          (wr && MEM_WRITEDATA !== wdata) || MEM_ERR !== 1'b0 ||
          (gnt_d ? D_BUSYWAIT : I_BUSYWAIT) !== 1'b1) bad++;
      if (perturb && n == 2) begin
        I_ADDRESS   = 28'($urandom);
        D_ADDRESS   = 28'($urandom);
        D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
        D_READ      = 1'b1;
        D_WRITE     = ~D_WRITE;
      end
      @(negedge CLK);
    end
    check({tag, "/hold_bad_cycles"}, 128'(bad), 128'd0);
    check({tag, "/cmd_cycles"}, 128'(n), 128'(exp_n));
    check({tag, "/resp_busywait"}, 128'(gnt_d ? D_BUSYWAIT : I_BUSYWAIT), 128'd0);
    check({tag, "/mem_err"}, 128'(MEM_ERR), 128'(err));
    if (!wr) begin
      check({tag, "/i_readdata"}, I_READDATA, exp_data);
      check({tag, "/d_readdata"}, D_READDATA, exp_data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ir, dr, dw, gnt_d, last_d;
    logic [127:0] rd;
    RESET = 1'b0; I_READ = 1'b1; D_READ = 1'b0; D_WRITE = 1'b0;
    I_ADDRESS = 28'd0; D_ADDRESS = 28'd0; D_WRITEDATA = 128'd0; MEM_READDATA = 128'd0;
    repeat (2) @(negedge CLK);
    check("rst/mem_read", 128'(MEM_READ), 128'd0);
    check("rst/mem_write", 128'(MEM_WRITE), 128'd0);
    check("rst/mem_err", 128'(MEM_ERR), 128'd0);
    check("rst/mem_address", 128'(MEM_ADDRESS), 128'd0);
    check("rst/mem_writedata", MEM_WRITEDATA, 128'd0);
    check("rst/readdata", I_READDATA | D_READDATA, 128'd0);
    check("rst/i_busywait", 128'(I_BUSYWAIT), 128'd1);
    check("rst/d_busywait", 128'(D_BUSYWAIT), 128'd0);

    // Single I read, 5-cycle memory.
    I_ADDRESS = 28'h0000010;
    RESET = 1'b1;
    serve("iread5", 1'b0, 1'b0, 28'h0000010, 128'd0,
          128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 5, 1, 1'b0);
    I_READ = 1'b0;
    @(negedge CLK);
    check("iread5/idle_busywait", 128'(I_BUSYWAIT), 128'd0);
    check("iread5/idle_mem_read", 128'(MEM_READ), 128'd0);

    // Simultaneous requests after reset alternate D, I, D, I.
    RESET = 1'b0;
    I_READ = 1'b1; D_READ = 1'b1; I_ADDRESS = 28'h0000100; D_ADDRESS = 28'h0000200;
    @(negedge CLK);
    RESET = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rd = {4{32'hA0B0_0000 + 32'(r)}};
      serve($sformatf("tie%0d", r), (r % 2) == 0, 1'b0, ((r % 2) == 0) ? 28'h0000200 : 28'h0000100,
            128'd0, rd, 2 + r, (r == 0) ? 1 : 2, 1'b0);
    end
    I_READ = 1'b0; D_READ = 1'b0;

    // Write-back with address and data disturbed mid-transaction.
    D_WRITE = 1'b1; D_ADDRESS = 28'h0000003;
    D_WRITEDATA = 128'h01234567_89ABCDEF_00112233_4455AA55;
    serve("dwrite", 1'b1, 1'b1, 28'h0000003, 128'h01234567_89ABCDEF_00112233_4455AA55,
          128'h0, 4, 2, 1'b1);
    D_WRITE = 1'b0; D_READ = 1'b0;

    // Read and write together: write wins; minimum-latency memory.
    D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 28'h00ABCDE; D_WRITEDATA = {4{32'h5A5A_1234}};
    serve("drw", 1'b1, 1'b1, 28'h00ABCDE, {4{32'h5A5A_1234}}, 128'h0, 1, 2, 1'b0);
    D_READ = 1'b0; D_WRITE = 1'b0;

    // Memory stuck busy: timeout abort.
    I_READ = 1'b1; I_ADDRESS = 28'h0000040;
    serve("timeout", 1'b0, 1'b0, 28'h0000040, 128'd0, {4{32'hFFFF_0001}}, 1000, 2, 1'b0);
    I_READ = 1'b0;
    @(negedge CLK);
    check("timeout/err_one_cycle", 128'(MEM_ERR), 128'd0);
    check("timeout/released", 128'(I_BUSYWAIT), 128'd0);

    // Reset in the middle of a D read.
    D_READ = 1'b1; D_ADDRESS = 28'h0000077; mem_lat = 50;
    repeat (3) @(negedge CLK);
    check("rstmid/mem_read_before", 128'(MEM_READ), 128'd1);
    #2 RESET = 1'b0;
    #1;
    check("rstmid/mem_read_drop", 128'(MEM_READ), 128'd0);
    check("rstmid/mem_address", 128'(MEM_ADDRESS), 128'd0);
    check("rstmid/d_busywait", 128'(D_BUSYWAIT), 128'd1);
    @(negedge CLK);
    D_READ = 1'b0; I_READ = 1'b1; I_ADDRESS = 28'h0000055;
    RESET = 1'b1;
    serve("rstmid/iread", 1'b0, 1'b0, 28'h0000055, 128'd0, {4{32'h1357_9BDF}}, 3, 1, 1'b0);
    I_READ = 1'b0;

    // Randomized traffic against the round-robin reference.
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    last_d = 1'b0;
    for (int it = 0; it < 30; it++) begin
      do begin
        ir = 1'($urandom_range(0, 1));
        dr = 1'($urandom_range(0, 1));
        dw = 1'($urandom_range(0, 1));
      end while (!(ir || dr || dw));
      I_READ = ir; D_READ = dr; D_WRITE = dw;
      I_ADDRESS = 28'($urandom); D_ADDRESS = 28'($urandom);
      D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      gnt_d = (ir && (dr || dw)) ? !last_d : (dr || dw);
      serve($sformatf("rnd%0d", it), gnt_d, gnt_d && dw, gnt_d ? D_ADDRESS : I_ADDRESS,
            D_WRITEDATA, rd, int'($urandom_range(1, 6)), (it == 0) ? 1 : 2, 1'b0);
      last_d = gnt_d;
    end
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
